// File: rtl/imem_loader_pkg.sv
// Shared constants and loader state encoding for the boot-time instruction
// memory loader. IMEM_SZ and INST_W must match the processor core's imem.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package imem_loader_pkg;

  // Instruction memory geometry, common with the core
  localparam int IMEM_SZ     = 16;
  localparam int INST_W      = 8;
  localparam int ADDR_W      = `CLOG2(IMEM_SZ);

  // Flops on each asynchronous pad input before it is used
  localparam int SYNC_STAGES = 2;

  // Loader FSM; the encoding is exported on state_out for debug display
  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } ld_state_e;

endpackage

// File: rtl/imem_loader_sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous pad input. With DETECT_EDGE=1
// the output is a one-cycle pulse on each synchronized rising edge; with
// DETECT_EDGE=0 the output is simply the synchronized level.
module imem_loader_sync_edge_detect #(
  parameter int SYNC_STAGES = 2,
  parameter bit DETECT_EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sig_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   synced;

  // Stage 0 samples the pad; later stages shift the value along the chain
  always_comb begin
    sync_d[0] = async_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchronizer chain, cleared by reset so no spurious edge follows release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  generate
    if (DETECT_EDGE) begin : g_edge
      logic prev_q;
      logic prev_d;

      // Previous synchronized value, for rising-edge detection
      always_comb begin
        prev_d = synced;
      end

      // Edge-history flop; keeps tracking even while the consumer ignores pulses
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q <= 1'b0;
        end else begin
          prev_q <= prev_d;
        end
      end

      assign sig_out = synced & ~prev_q;
    end else begin : g_level
      assign sig_out = synced;
    end
  endgenerate

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader. After reset it samples the load-mode pin; in load
// mode it writes IMEM_SZ strobed bytes into the core's imem, then compares a
// trailing XOR checksum byte. The core is released only on a good checksum, or
// immediately when loading is bypassed.
module imem_loader #(
  parameter int IMEM_SZ     = imem_loader_pkg::IMEM_SZ,
  parameter int INST_W      = imem_loader_pkg::INST_W,
  parameter int SYNC_STAGES = imem_loader_pkg::SYNC_STAGES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ld_mode_in,
  input  logic                       ld_strobe_in,
  input  logic [INST_W-1:0]          ld_data_in,
  output logic                       imem_we_out,
  output logic [$clog2(IMEM_SZ)-1:0] imem_waddr_out,
  output logic [INST_W-1:0]          imem_wdata_out,
  output logic                       core_run_out,
  output logic                       load_err_out,
  output logic [2:0]                 state_out
);

  import imem_loader_pkg::*;

  localparam int AW = $clog2(IMEM_SZ);

  // BOOT lingers long enough for the mode pin to clear the synchronizer
  localparam logic [1:0]    WAIT_LAST = 2'(SYNC_STAGES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_SZ - 1);

  logic stb;
  logic mode_sync;

  ld_state_e         state_q,  state_d;
  logic [1:0]        wait_q,   wait_d;
  logic [AW-1:0]     cnt_q,    cnt_d;
  logic [INST_W-1:0] acc_q,    acc_d;
  logic              we_q,     we_d;
  logic [AW-1:0]     waddr_q,  waddr_d;
  logic [INST_W-1:0] wdata_q,  wdata_d;
  logic              run_q,    run_d;
  logic              err_q,    err_d;

  imem_loader_sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .DETECT_EDGE (1'b1)
  ) u_strobe_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ld_strobe_in),
    .sig_out  (stb)
  );

  imem_loader_sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .DETECT_EDGE (1'b0)
  ) u_mode_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ld_mode_in),
    .sig_out  (mode_sync)
  );

  // Next-state logic: boot decision, byte capture, checksum verdict
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    // The release follows RUN by one cycle so the core reset comes from a flop
    run_d   = (state_q == ST_RUN);
    err_d   = err_q;

    case (state_q)
      ST_BOOT: begin
        // Strobes are ignored here; the edge detector still tracks the pin
        if (wait_q == WAIT_LAST) begin
          state_d = mode_sync ? ST_LOAD : ST_RUN;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      ST_LOAD: begin
        if (stb) begin
          // Data pins are held long enough to be sampled raw in the stb cycle
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = ld_data_in;
          acc_d   = acc_q ^ ld_data_in;
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = ST_CHECK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_CHECK: begin
        if (stb) begin
          if (ld_data_in == acc_q) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
      end

      ST_RUN, ST_ERROR: begin
        // Terminal until the next reset
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Loader FSM and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      wait_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign imem_we_out    = we_q;
  assign imem_waddr_out = waddr_q;
  assign imem_wdata_out = wdata_q;
  assign core_run_out   = run_q;
  assign load_err_out   = err_q;
  assign state_out      = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed byte streams, a transaction-level model of
// the expected imem writes and final verdict, and a per-cycle compare process.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_mode_in = 1'b0;
  logic       ld_strobe_in = 1'b0;
  logic [7:0] ld_data_in = 8'h00;
  logic       imem_we_out;
  logic [3:0] imem_waddr_out;
  logic [7:0] imem_wdata_out;
  logic       core_run_out;
  logic       load_err_out;
  logic [2:0] state_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ld_mode_in     (ld_mode_in),
    .ld_strobe_in   (ld_strobe_in),
    .ld_data_in     (ld_data_in),
    .imem_we_out    (imem_we_out),
    .imem_waddr_out (imem_waddr_out),
    .imem_wdata_out (imem_wdata_out),
    .core_run_out   (core_run_out),
    .load_err_out   (load_err_out),
    .state_out      (state_out)
  );

  logic [7:0] prog [16] = '{8'h5B, 8'h07, 8'h1B, 8'h17, 8'h13, 8'h0E, 8'h17, 8'h03,
                            8'hF8, 8'h07, 8'h4F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  // ---------------- behavioural model ----------------
  typedef enum {M_LOAD, M_CHECK, M_RUN, M_ERROR} mphase_t;
  mphase_t     m_phase = M_RUN;
  int          m_count = 0;
  logic [7:0]  m_xor = 8'h00;
  logic [11:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_byte(input logic [7:0] d);
    logic [3:0] a;
    case (m_phase)
      M_LOAD: begin
        a = 4'(m_count);
        exp_q.push_back({a, d});
        m_xor = m_xor ^ d;
        m_count++;
        if (m_count == 16) begin
          m_count = 0;
          m_phase = M_CHECK;
        end
      end
      M_CHECK: m_phase = (d == m_xor) ? M_RUN : M_ERROR;
      default: ;
    endcase
  endfunction

  function automatic logic [2:0] model_state();
    case (m_phase)
      M_LOAD:  return 3'd1;
      M_CHECK: return 3'd2;
      M_RUN:   return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  logic prev_we = 1'b0;
  always @(posedge clk) begin
    logic [11:0] e;
    #1;
    if (prev_we) check("we_width", imem_we_out, 1'b0);
    if (imem_we_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %02h, expected no write", imem_waddr_out, imem_wdata_out);
      end else begin
        e = exp_q.pop_front();
        check("waddr", imem_waddr_out, e[11:8]);
        check("wdata", imem_wdata_out, e[7:0]);
        $display("write addr=%0d data=%02h", imem_waddr_out, imem_wdata_out);
      end
    end
    if (core_run_out) check("run_only_in_run", state_out, 3'd3);
    prev_we = imem_we_out;
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_reset(input logic mode);
    @(negedge clk);
    rst_n = 1'b0;
    ld_mode_in = mode;
    ld_strobe_in = 1'b0;
    exp_q.delete();
    m_xor = 8'h00;
    m_count = 0;
    m_phase = mode ? M_LOAD : M_RUN;
    #1;
    check("rst_we", imem_we_out, 1'b0);
    check("rst_waddr", imem_waddr_out, 4'd0);
    check("rst_wdata", imem_wdata_out, 8'h00);
    check("rst_run", core_run_out, 1'b0);
    check("rst_err", load_err_out, 1'b0);
    check("rst_state", state_out, 3'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_boot(input logic [2:0] exp_state);
    int n = 0;
    while (state_out != exp_state && n < 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("boot_state", state_out, exp_state);
    $display("boot done: state=%0d after %0d cycles", state_out, n);
  endtask

  task automatic send_byte(input logic [7:0] d, input int hold);
    @(negedge clk);
    ld_data_in = d;
    ld_strobe_in = 1'b1;
    model_byte(d);
    repeat (hold) @(negedge clk);
    ld_strobe_in = 1'b0;
    repeat (6) @(negedge clk);
    check("write_drained", exp_q.size(), 0);
  endtask

  task automatic send_stream(input logic [7:0] csum, input int hold);
    for (int i = 0; i < 16; i++) send_byte(prog[i], hold);
    check("model_xor", m_xor, 8'hE9);
    send_byte(csum, hold);
  endtask

  task automatic check_final(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_state"}, state_out, model_state());
    check({tag, "_run"}, core_run_out, m_phase == M_RUN);
    check({tag, "_err"}, load_err_out, m_phase == M_ERROR);
    $display("%s: state=%0d run=%0d err=%0d", tag, state_out, core_run_out, load_err_out);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // 1. Bypass: straight to RUN, strobes afterwards ignored
    do_reset(1'b0);
    wait_boot(3'd3);
    @(posedge clk); #1;
    check("bypass_run", core_run_out, 1'b1);
    send_byte(8'h55, 5);
    send_byte(8'hAA, 5);
    check_final("bypass");

    // 2. Full load with good checksum; mode pin changed after the boot decision
    do_reset(1'b1);
    wait_boot(3'd1);
    ld_mode_in = 1'b0;
    send_byte(prog[0], 5);
    check("load_state", state_out, 3'd1);
    for (int i = 1; i < 16; i++) send_byte(prog[i], 5);
    check("check_state", state_out, 3'd2);
    check("model_xor", m_xor, 8'hE9);
    send_byte(8'hE9, 5);
    check_final("good_load");
    check("good_load_lit_state", state_out, 3'd3);
    check("good_load_lit_run", core_run_out, 1'b1);

    // 3. Bad checksum: ERROR, no release, no further writes
    do_reset(1'b1);
    wait_boot(3'd1);
    send_stream(8'hE8, 5);
    check_final("bad_load");
    check("bad_load_lit_state", state_out, 3'd4);
    check("bad_load_lit_err", load_err_out, 1'b1);
    send_byte(8'h12, 5);
    send_byte(8'h34, 5);
    check_final("bad_after");

    // 4. Latency: write visible after the 3rd edge, sampled by imem at the 4th
    do_reset(1'b1);
    wait_boot(3'd1);
    @(negedge clk);
    ld_data_in = 8'hA5;
    ld_strobe_in = 1'b1;
    model_byte(8'hA5);
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      check($sformatf("latency_edge%0d", e), imem_we_out, e == 3);
    end
    ld_strobe_in = 1'b0;
    repeat (6) @(negedge clk);

    // 5. Reset after 7 bytes, then a fresh full stream
    for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i), 5);
    check("partial_state", state_out, 3'd1);
    do_reset(1'b1);
    wait_boot(3'd1);
    send_stream(8'hE9, 5);
    check_final("reload");

    // 6. Long strobes: one write per strobe, clean wrap into CHECK
    do_reset(1'b1);
    wait_boot(3'd1);
    send_stream(8'hE9, 20);
    check_final("long_strobe");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader, directly upstream of the processor core's instruction memory.
- Receives 16 instruction bytes plus one XOR checksum byte over an 8-bit parallel port, qualified by an asynchronous strobe.
- Generates imem write pulses and holds the core in reset until loading completes, or bypasses loading so the core runs its built-in reset program.
- Sits in the top level between the pad inputs (uio_in, ui_in) and the core's imem write port / core reset.

Parameters:
IMEM_SZ, 16, number of instruction words loaded; address width = CLOG2(IMEM_SZ) = 4
INST_W, 8, instruction/data byte width
SYNC_STAGES, 2, flip-flop stages on the asynchronous strobe and mode inputs

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
ld_mode_in  input  1  pad ui_in[6]; 1 = load program at boot, 0 = run built-in program
ld_strobe_in  input  1  pad ui_in[7]; asynchronous byte strobe, rising edge = new byte
ld_data_in  input  8  pad uio_in; byte value, held stable from strobe rise until strobe fall
imem_we_out  output  1  one-cycle imem write enable
imem_waddr_out  output  4  imem write address
imem_wdata_out  output  8  imem write data
core_run_out  output  1  1 = core released; core reset = ~rst_n | ~core_run_out
load_err_out  output  1  checksum mismatch, sticky
state_out  output  3  encoded FSM state, for debug/seven-seg

Behaviour:
- Reset (async, rst_n=0) values:
  - imem_we_out=0, imem_waddr_out=0, imem_wdata_out=0, core_run_out=0, load_err_out=0
  - FSM=BOOT; sync chains=0, byte counter=0, checksum accumulator=0
- Input synchronization:
  - ld_strobe_in and ld_mode_in each pass through SYNC_STAGES flops.
  - Strobe rising edge = synced=1 and previous synced=0 (one extra flop).
  - Edge-detect pulse "stb" is high for one cycle, at the 3rd clk edge after the pin rises (SYNC_STAGES+1).
  - ld_data_in is sampled unsynchronized in the stb cycle; pad-side hold requirement is therefore ≥4 clk periods.
- FSM states, state_out encoding: BOOT=0, LOAD=1, CHECK=2, RUN=3, ERROR=4.
- BOOT:
  - Waits SYNC_STAGES+1 cycles after reset release (2-bit wait counter), then reads synced mode.
  - mode=1 -> LOAD; mode=0 -> RUN.
  - Strobes during BOOT are ignored; the edge-detect flop is still updated.
- LOAD, on stb:
  - imem_we_out=1 next cycle for exactly one cycle.
  - imem_waddr_out = counter, imem_wdata_out = ld_data_in.
  - counter increments; accumulator ^= data.
  - After the write with counter=IMEM_SZ-1, counter wraps to 0 and FSM -> CHECK.
- CHECK, on stb:
  - Byte is compared with the accumulator; no imem write.
  - Equal -> RUN; unequal -> ERROR.
- RUN:
  - core_run_out=1, registered, asserted the cycle after entering RUN.
  - All further strobes ignored; ld_mode_in ignored after BOOT.
  - Terminal until reset.
- ERROR:
  - core_run_out=0, load_err_out=1.
  - Strobes ignored; terminal until reset.
- Write timing: at most one imem write per stb; strobe pulses closer than 2 synced cycles may merge into one edge, and this is not detected.
- core_run_out never toggles outside RUN; no glitch — it is driven from a flop.
- Reset mid-load: async reset returns to BOOT with counter/accumulator cleared.
  - The core's imem is re-initialised by its own reset, so partial loads are discarded.
- Mode change after BOOT decision has no effect.

Decomposition:
- Shared package holds:
  - CLOG2 macro
  - IMEM_SZ, INST_W constants, common with the core
  - loader state encoding constants (ST_BOOT..ST_ERROR)
- One natural sub-module: sync_edge_detect — parameterised SYNC_STAGES synchronizer plus rising-edge pulse, async active-low reset.
  - Instantiated for the strobe.
  - The mode input uses the synchronizer path only.

Test Plan:
1. Bypass:
   - Stimulus: rst_n low→high with ld_mode_in=0.
   - Response: state_out 0→3 within 4 cycles, core_run_out=1, no imem_we_out pulse, strobes afterwards ignored.
2. Full load:
   - Stimulus: mode=1; strobe bytes 5B,07,1B,17,13,0E,17,03,F8,07,4F,00,00,00,00,00, then checksum E9.
   - Response: 16 one-cycle writes at addr 0..15 with matching data, state 1→2→3, core_run_out=1, load_err_out=0.
3. Bad checksum:
   - Stimulus: same stream with checksum E8.
   - Response: state=4, load_err_out=1, core_run_out stays 0, further strobes produce no writes.
4. Latency:
   - Stimulus: single strobe rising between edges.
   - Response: imem_we_out high on exactly the 4th rising clk edge after the pin rises, width 1 cycle.
5. Reset mid-load:
   - Stimulus: assert rst_n low after 7 bytes, release with mode=1, send a full 16+1 stream.
   - Response: first write after reset goes to addr 0, checksum of the new stream only, RUN reached.
6. Long strobe:
   - Stimulus: strobe held high 20 cycles per byte.
   - Response: exactly one write per strobe; wrap from addr 15 to CHECK, no write to addr 0.
